// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
//   Registered, valid/ready handshaked uDLX decode stage. Decodes one
//   instruction per cycle into a registered bundle with sign-extended
//   immediate and jump offset. Includes flush, a load-use interlock that
//   drains the LW and then inserts LOAD_USE_BUBBLES bubbles, and an
//   optional illegal-opcode trap.
//
//   Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//     defined   : unknown non-zero opcodes produce an all-zero bundle with
//                 illegal_inst_out=1 (qualified by dec_valid_out).
//     undefined : illegal_inst_out is tied 0, unknown opcodes are NOPs.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     flush_in                      kill held instruction and interlock
//     inst_valid_in/inst_ready_out  upstream handshake
//     instruction_in, pc_in         instruction word and its PC
//     dec_valid_out/dec_ready_in    downstream handshake
//     opcode_out .. jump_use_r_out  registered decoded bundle
//     pc_out                        PC of the held instruction
//     hazard_stall_out              interlock active this cycle
//     illegal_inst_out              illegal opcode trap flag
//
//   Opcode encodings mirror the shared opcodes.v definitions.
module decode_stage_pipe #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int IMEDIATE_WIDTH    = 16,
  parameter int PC_OFFSET_WIDTH   = 26,
  parameter int LOAD_USE_BUBBLES  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_in,
  input  logic                         inst_valid_in,
  output logic                         inst_ready_out,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic [DATA_WIDTH-1:0]        pc_in,
  output logic                         dec_valid_out,
  input  logic                         dec_ready_in,
  output logic [OPCODE_WIDTH-1:0]      opcode_out,
  output logic [FUNCTION_WIDTH-1:0]    inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_rd_addr1_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_rd_addr2_out,
  output logic                         reg_rd_en1_out,
  output logic                         reg_rd_en2_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic                         reg_wr_en_out,
  output logic [DATA_WIDTH-1:0]        immediate_out,
  output logic                         imm_inst_out,
  output logic [DATA_WIDTH-1:0]        pc_offset_out,
  output logic                         mem_data_rd_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic                         jump_use_r_out,
  output logic [DATA_WIDTH-1:0]        pc_out,
  output logic                         hazard_stall_out,
  output logic                         illegal_inst_out
);

  localparam logic [OPCODE_WIDTH-1:0] OP_R_TYPE = OPCODE_WIDTH'('h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_JPC    = OPCODE_WIDTH'('h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQZ   = OPCODE_WIDTH'('h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNEZ   = OPCODE_WIDTH'('h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRFL   = OPCODE_WIDTH'('h06);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = OPCODE_WIDTH'('h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI   = OPCODE_WIDTH'('h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI   = OPCODE_WIDTH'('h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI    = OPCODE_WIDTH'('h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_JR     = OPCODE_WIDTH'('h12);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW     = OPCODE_WIDTH'('h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW     = OPCODE_WIDTH'('h2B);

  localparam int OP_LSB = INSTRUCTION_WIDTH - OPCODE_WIDTH;
  localparam int RS_LSB = OP_LSB - REG_ADDR_WIDTH;
  localparam int RT_LSB = RS_LSB - REG_ADDR_WIDTH;
  localparam int RD_LSB = IMEDIATE_WIDTH - REG_ADDR_WIDTH;
  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_USE_BUBBLES);
  localparam bit         LU_EN       = (LOAD_USE_BUBBLES != 0);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_BUBBLE} state_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [FUNCTION_WIDTH-1:0] func;
    logic [REG_ADDR_WIDTH-1:0] rd1;
    logic [REG_ADDR_WIDTH-1:0] rd2;
    logic                      rd_en1;
    logic                      rd_en2;
    logic [REG_ADDR_WIDTH-1:0] wr;
    logic                      wr_en;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      imm_inst;
    logic [DATA_WIDTH-1:0]     pc_off;
    logic                      mem_rd;
    logic                      mem_wr;
    logic                      wb_sel;
    logic                      branch;
    logic                      jump;
    logic                      jump_r;
  } bundle_t;

  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [REG_ADDR_WIDTH-1:0] f_rs, f_rt, f_rd;
  logic [DATA_WIDTH-1:0]     imm_sext, off_sext;
  bundle_t                   dec;
  bundle_t                   bundle_q, bundle_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic                      valid_q, valid_d;
  logic                      lu_pending_q, lu_pending_d;
  logic [REG_ADDR_WIDTH-1:0] lu_dest_q, lu_dest_d;
  logic [1:0]                bubble_cnt_q, bubble_cnt_d;
  state_t                    state_q, state_d;
  logic                      hazard, accept;

  assign opcode   = instruction_in[OP_LSB +: OPCODE_WIDTH];
  assign f_rs     = instruction_in[RS_LSB +: REG_ADDR_WIDTH];
  assign f_rt     = instruction_in[RT_LSB +: REG_ADDR_WIDTH];
  assign f_rd     = instruction_in[RD_LSB +: REG_ADDR_WIDTH];
  assign imm_sext = {{(DATA_WIDTH-IMEDIATE_WIDTH){instruction_in[IMEDIATE_WIDTH-1]}},
                     instruction_in[IMEDIATE_WIDTH-1:0]};
  assign off_sext = {{(DATA_WIDTH-PC_OFFSET_WIDTH){instruction_in[PC_OFFSET_WIDTH-1]}},
                     instruction_in[PC_OFFSET_WIDTH-1:0]};

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q, illegal_d;
`endif

  // Combinational decode of the incoming word; the all-zero word shares
  // the R-type opcode but must decode to an empty bundle.
  always_comb begin
    dec = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    if (instruction_in != '0) begin
      dec.opcode = opcode;
      case (opcode)
        OP_R_TYPE: begin
          dec.rd1 = f_rs; dec.rd2 = f_rt; dec.rd_en1 = 1'b1; dec.rd_en2 = 1'b1;
          dec.wr = f_rd; dec.wr_en = 1'b1;
          dec.func = instruction_in[FUNCTION_WIDTH-1:0];
        end
        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW: begin
          dec.rd1 = f_rs; dec.rd_en1 = 1'b1;
          dec.wr = f_rt; dec.wr_en = 1'b1;
          dec.imm = imm_sext; dec.imm_inst = 1'b1;
          dec.mem_rd = (opcode == OP_LW);
          dec.wb_sel = (opcode == OP_LW);
        end
        OP_SW: begin
          dec.rd1 = f_rs; dec.rd2 = f_rt; dec.rd_en1 = 1'b1; dec.rd_en2 = 1'b1;
          dec.imm = imm_sext; dec.imm_inst = 1'b1; dec.mem_wr = 1'b1;
        end
        OP_BEQZ, OP_BNEZ, OP_BRFL: begin
          dec.rd1 = f_rs; dec.rd_en1 = 1'b1;
          dec.imm = imm_sext; dec.imm_inst = 1'b1; dec.branch = 1'b1;
        end
        OP_JR: begin
          dec.rd1 = f_rs; dec.rd_en1 = 1'b1; dec.jump = 1'b1; dec.jump_r = 1'b1;
        end
        OP_JPC: begin
          dec.pc_off = off_sext; dec.jump = 1'b1;
        end
        default: begin
          dec.opcode = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
          dec_illegal = 1'b1;
`endif
        end
      endcase
    end
  end

  // lu_dest is never 0, so register 0 can never match.
  always_comb begin
    hazard = LU_EN & lu_pending_q & inst_valid_in &
             ((dec.rd_en1 & (dec.rd1 == lu_dest_q)) |
              (dec.rd_en2 & (dec.rd2 == lu_dest_q)));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d      = state_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_in) begin
      state_d      = S_RUN;
      bubble_cnt_d = '0;
    end else begin
      case (state_q)
        S_RUN:    if (hazard) state_d = S_DRAIN;
        S_DRAIN:  if (!(valid_q && !dec_ready_in)) begin
                    state_d      = S_BUBBLE;
                    bubble_cnt_d = BUBBLE_INIT;
                  end
        S_BUBBLE: begin
                    bubble_cnt_d = bubble_cnt_q - 2'd1;
                    if (bubble_cnt_q <= 2'd1) begin
                      state_d      = S_RUN;
                      bubble_cnt_d = '0;
                    end
                  end
        default:  state_d = S_RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    hazard_stall_out = hazard | (state_q != S_RUN);
    inst_ready_out   = (!valid_q | dec_ready_in) & (state_q == S_RUN) & !hazard & !flush_in;
  end

  assign accept = inst_valid_in & inst_ready_out;

  always_comb begin
    valid_d      = valid_q;
    bundle_d     = bundle_q;
    pc_d         = pc_q;
    lu_pending_d = lu_pending_q;
    lu_dest_d    = lu_dest_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    if (flush_in) begin
      valid_d      = 1'b0;
      lu_pending_d = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_d    = 1'b0;
`endif
    end else if (accept) begin
      valid_d      = 1'b1;
      bundle_d     = dec;
      pc_d         = pc_in;
      lu_pending_d = LU_EN & dec.mem_rd & (dec.wr != '0);
      lu_dest_d    = dec.wr;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_d    = dec_illegal;
`endif
    end else begin
      if (dec_ready_in) begin
        valid_d   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d = 1'b0;
`endif
      end
      if (state_q == S_BUBBLE && bubble_cnt_q <= 2'd1) lu_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      bundle_q     <= '0;
      pc_q         <= '0;
      lu_pending_q <= 1'b0;
      lu_dest_q    <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      valid_q      <= valid_d;
      bundle_q     <= bundle_d;
      pc_q         <= pc_d;
      lu_pending_q <= lu_pending_d;
      lu_dest_q    <= lu_dest_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  // Side-effecting controls are suppressed in an empty slot.
  assign dec_valid_out          = valid_q;
  assign opcode_out             = bundle_q.opcode;
  assign inst_function_out      = bundle_q.func;
  assign reg_rd_addr1_out       = bundle_q.rd1;
  assign reg_rd_addr2_out       = bundle_q.rd2;
  assign reg_rd_en1_out         = bundle_q.rd_en1;
  assign reg_rd_en2_out         = bundle_q.rd_en2;
  assign reg_wr_addr_out        = bundle_q.wr;
  assign reg_wr_en_out          = bundle_q.wr_en & valid_q;
  assign immediate_out          = bundle_q.imm;
  assign imm_inst_out           = bundle_q.imm_inst;
  assign pc_offset_out          = bundle_q.pc_off;
  assign mem_data_rd_en_out     = bundle_q.mem_rd & valid_q;
  assign mem_data_wr_en_out     = bundle_q.mem_wr & valid_q;
  assign write_back_mux_sel_out = bundle_q.wb_sel;
  assign branch_inst_out        = bundle_q.branch & valid_q;
  assign jump_inst_out          = bundle_q.jump & valid_q;
  assign jump_use_r_out         = bundle_q.jump_r & valid_q;
  assign pc_out                 = pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_inst_out       = illegal_q & valid_q;
`else
  assign illegal_inst_out       = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  localparam int NB = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush_in = 1'b0, inst_valid_in = 1'b0, dec_ready_in = 1'b0;
  logic [31:0] instruction_in = '0, pc_in = '0;
  logic        inst_ready_out, dec_valid_out;
  logic [5:0]  opcode_out, inst_function_out;
  logic [4:0]  reg_rd_addr1_out, reg_rd_addr2_out, reg_wr_addr_out;
  logic        reg_rd_en1_out, reg_rd_en2_out, reg_wr_en_out, imm_inst_out;
  logic [31:0] immediate_out, pc_offset_out, pc_out;
  logic        mem_data_rd_en_out, mem_data_wr_en_out, write_back_mux_sel_out;
  logic        branch_inst_out, jump_inst_out, jump_use_r_out;
  logic        hazard_stall_out, illegal_inst_out;

  decode_stage_pipe #(.LOAD_USE_BUBBLES(NB)) dut (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .inst_valid_in(inst_valid_in), .inst_ready_out(inst_ready_out),
    .instruction_in(instruction_in), .pc_in(pc_in),
    .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in),
    .opcode_out(opcode_out), .inst_function_out(inst_function_out),
    .reg_rd_addr1_out(reg_rd_addr1_out), .reg_rd_addr2_out(reg_rd_addr2_out),
    .reg_rd_en1_out(reg_rd_en1_out), .reg_rd_en2_out(reg_rd_en2_out),
    .reg_wr_addr_out(reg_wr_addr_out), .reg_wr_en_out(reg_wr_en_out),
    .immediate_out(immediate_out), .imm_inst_out(imm_inst_out),
    .pc_offset_out(pc_offset_out),
    .mem_data_rd_en_out(mem_data_rd_en_out), .mem_data_wr_en_out(mem_data_wr_en_out),
    .write_back_mux_sel_out(write_back_mux_sel_out),
    .branch_inst_out(branch_inst_out), .jump_inst_out(jump_inst_out),
    .jump_use_r_out(jump_use_r_out), .pc_out(pc_out),
    .hazard_stall_out(hazard_stall_out), .illegal_inst_out(illegal_inst_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e1;
    logic        e2;
    logic [4:0]  wr;
    logic        we;
    logic [31:0] imm;
    logic        ii;
    logic [31:0] off;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        br;
    logic        j;
    logic        jr;
  } dec_t;

  int total = 0;
  int bad   = 0;

  // Reference state: what the stage is holding and how far the interlock has got.
  dec_t        m_b;
  logic [31:0] m_pc;
  bit          m_valid, m_ill, m_pend, m_drain;
  logic [4:0]  m_dest;
  int          m_bub;

  logic [133:0] obs;
  assign obs = {opcode_out, inst_function_out, reg_rd_addr1_out, reg_rd_addr2_out,
                reg_rd_en1_out, reg_rd_en2_out, reg_wr_addr_out, reg_wr_en_out,
                immediate_out, imm_inst_out, pc_offset_out, mem_data_rd_en_out,
                mem_data_wr_en_out, write_back_mux_sel_out, branch_inst_out,
                jump_inst_out, jump_use_r_out, pc_out, illegal_inst_out};

  function automatic dec_t ref_decode(input logic [31:0] w, output bit ill);
    dec_t d;
    int   op, rs, rt, rd;
    logic [31:0] simm, soff;
    d   = '0;
    ill = 1'b0;
    op  = int'(w >> 26);
    rs  = int'((w >> 21) & 32'h1F);
    rt  = int'((w >> 16) & 32'h1F);
    rd  = int'((w >> 11) & 32'h1F);
    simm = ((w & 32'h8000) != 0) ? ((w & 32'hFFFF) | 32'hFFFF0000) : (w & 32'hFFFF);
    soff = ((w & 32'h0200_0000) != 0) ? ((w & 32'h03FF_FFFF) | 32'hFC00_0000) : (w & 32'h03FF_FFFF);
    if (w == 0) return d;
    d.op = 6'(op);
    case (op)
      0:              begin d.r1 = 5'(rs); d.r2 = 5'(rt); d.e1 = 1; d.e2 = 1;
                            d.wr = 5'(rd); d.we = 1; d.fn = 6'(w & 32'h3F); end
      8, 10, 12, 13:  begin d.r1 = 5'(rs); d.e1 = 1; d.wr = 5'(rt); d.we = 1;
                            d.imm = simm; d.ii = 1; end
      35:             begin d.r1 = 5'(rs); d.e1 = 1; d.wr = 5'(rt); d.we = 1;
                            d.imm = simm; d.ii = 1; d.mr = 1; d.wb = 1; end
      43:             begin d.r1 = 5'(rs); d.r2 = 5'(rt); d.e1 = 1; d.e2 = 1;
                            d.imm = simm; d.ii = 1; d.mw = 1; end
      4, 5, 6:        begin d.r1 = 5'(rs); d.e1 = 1; d.imm = simm; d.ii = 1; d.br = 1; end
      18:             begin d.r1 = 5'(rs); d.e1 = 1; d.j = 1; d.jr = 1; end
      2:              begin d.off = soff; d.j = 1; end
      default:        begin d = '0; ill = TRAP; end
    endcase
    return d;
  endfunction

  function automatic logic [133:0] exp_vec();
    bit v;
    v = m_valid;
    return {m_b.op, m_b.fn, m_b.r1, m_b.r2, m_b.e1, m_b.e2, m_b.wr, m_b.we & v,
            m_b.imm, m_b.ii, m_b.off, m_b.mr & v, m_b.mw & v, m_b.wb,
            m_b.br & v, m_b.j & v, m_b.jr & v, m_pc, m_ill & v};
  endfunction

  task automatic chk(input string tag, input logic [133:0] o, input logic [133:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_b = '0; m_pc = '0; m_valid = 0; m_ill = 0; m_pend = 0; m_drain = 0;
    m_dest = '0; m_bub = 0;
  endtask

  // One clock: drive inputs, check handshake outputs, advance the model,
  // clock, then check the registered bundle. acc reports a DUT accept.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, input bit rs, output bit acc);
    dec_t d;
    bit   dill, haz, stalled, e_ready, held, macc;
    @(negedge clk);
    inst_valid_in = v; instruction_in = ins; pc_in = pc;
    dec_ready_in = rdy; flush_in = fl; rst = rs;
    #1;
    d       = ref_decode(ins, dill);
    haz     = (NB > 0) && m_pend && v &&
              ((d.e1 && d.r1 == m_dest) || (d.e2 && d.r2 == m_dest));
    stalled = m_drain || (m_bub > 0);
    e_ready = (!m_valid || rdy) && !stalled && !haz && !fl;
    acc     = v && (inst_ready_out === 1'b1);
    if (!rs) begin
      chk("inst_ready", 134'(inst_ready_out), 134'(e_ready));
      chk("hazard_stall", 134'(hazard_stall_out), 134'(haz || stalled));
    end
    if (rs) model_reset();
    else if (fl) begin
      m_valid = 0; m_ill = 0; m_pend = 0; m_drain = 0; m_bub = 0;
    end else begin
      macc = v && e_ready;
      held = m_valid && !rdy;
      if (macc) begin
        m_b = d; m_pc = pc; m_valid = 1; m_ill = dill;
        m_pend = (NB > 0) && (d.op == 6'd35) && (d.wr != 0);
        m_dest = d.wr;
      end else if (rdy) begin
        m_valid = 0; m_ill = 0;
      end
      if (m_drain) begin
        if (!held) begin m_drain = 0; m_bub = NB; end
      end else if (m_bub > 0) begin
        if (m_bub == 1) m_pend = 0;
        m_bub--;
      end else if (haz) m_drain = 1;
    end
    @(posedge clk);
    #1;
    chk("dec_valid", 134'(dec_valid_out), 134'(m_valid));
    chk("bundle", obs, exp_vec());
  endtask

  // Present one instruction until the DUT takes it; n = cycles used.
  task automatic push(input logic [31:0] ins, input logic [31:0] pc, output int n);
    bit acc;
    acc = 0; n = 0;
    while (!acc && n < 30) begin
      step(1, ins, pc, 1, 0, 0, acc);
      n++;
    end
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL push_timeout ins=%h observed=not accepted expected=accepted within 30 cycles", ins);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0]  ops [14];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0D,
            6'h12, 6'h23, 6'h23, 6'h2B, 6'h3F};
    if ($urandom_range(0, 19) == 0) return 32'h0;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 13)];
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    bit acc;
    int n;
    model_reset();

    // reset
    step(0, 32'h0, 32'h0, 0, 0, 1, acc);
    step(0, 32'h0, 32'h0, 0, 0, 1, acc);
    chk("reset_zero", obs, 134'h0);
    step(0, 32'h0, 32'h0, 1, 0, 0, acc);

    // ADD r3,r1,r2
    push(32'h0022_1820, 32'h100, n);
    chk("add_wr", 134'(reg_wr_addr_out), 134'd3);
    chk("add_fn", 134'(inst_function_out), 134'h20);
    chk("add_rd", 134'({reg_rd_addr1_out, reg_rd_addr2_out, reg_wr_en_out}), 134'({5'd1, 5'd2, 1'b1}));

    // ADDI r5,r4,-4 and JPC with all-ones offset
    push(32'h2085_FFFC, 32'h104, n);
    chk("addi_imm", 134'(immediate_out), 134'hFFFF_FFFC);
    chk("addi_iflag", 134'(imm_inst_out), 134'd1);
    push(32'h0BFF_FFFF, 32'h108, n);
    chk("jpc_off", 134'(pc_offset_out), 134'hFFFF_FFFF);

    // backpressure: bundle held three cycles, ORI taken when ready rises
    push(32'h0022_1820, 32'h10C, n);
    for (int i = 0; i < 3; i++) step(1, 32'h3443_0011, 32'h110, 0, 0, 0, acc);
    chk("held_pc", 134'(pc_out), 134'h10C);
    push(32'h3443_0011, 32'h110, n);
    chk("bp_accept_first", 134'(n), 134'd1);

    // load-use: LW r7 then dependent ADD r8,r7,r2
    push(32'h8C27_0000, 32'h200, n);
    push(32'h00E2_4020, 32'h204, n);
    chk("lu_stall_cycles", 134'(n), 134'(NB + 3));
    // independent ADD r8,r9,r2 after LW: no bubble
    push(32'h8C27_0000, 32'h208, n);
    push(32'h0122_4020, 32'h20C, n);
    chk("lu_no_bubble", 134'(n), 134'd1);

    // flush in the first bubble cycle
    push(32'h8C27_0000, 32'h300, n);
    step(1, 32'h00E2_4020, 32'h304, 1, 0, 0, acc);
    step(1, 32'h00E2_4020, 32'h304, 1, 0, 0, acc);
    step(1, 32'h00E2_4020, 32'h304, 1, 1, 0, acc);
    chk("flush_valid", 134'(dec_valid_out), 134'd0);
    push(32'h00E2_4020, 32'h304, n);
    chk("flush_accept", 134'(n), 134'd1);

    // reset in the middle of a stall
    push(32'h8C27_0000, 32'h400, n);
    step(1, 32'h00E2_4020, 32'h404, 0, 0, 0, acc);
    step(1, 32'h00E2_4020, 32'h404, 0, 0, 1, acc);
    chk("rst_stall_zero", obs, 134'h0);
    chk("rst_stall_hz", 134'(hazard_stall_out), 134'd0);

    // unknown opcode 0x3F
    push(32'hFC22_1820, 32'h500, n);
    chk("illegal_flag", 134'(illegal_inst_out), 134'(TRAP));
    chk("illegal_op", 134'(opcode_out), 134'd0);
    step(0, 32'h0, 32'h0, 1, 0, 0, acc);
    chk("illegal_clear", 134'(illegal_inst_out), 134'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 199) == 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
